// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and types for the multi-port register file with busy scoreboard.
package regfile_mp_sb_pkg;

    localparam int unsigned DEF_XLEN  = 32;
    localparam int unsigned DEF_NREGS = 32;
    localparam int unsigned DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_XLEN-1:0] xword_t;
    typedef logic [DEF_AW-1:0]   regidx_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves all write ports against one address: the highest-index matching port wins.
module regfile_wr_arb
    import regfile_mp_sb_pkg::*;
#(
    parameter int unsigned XLEN    = DEF_XLEN,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned NUM_WR  = 1,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic [AW-1:0]          addr,
    input  logic [NUM_WR-1:0]      wer,
    input  logic [NUM_WR*AW-1:0]   rd,
    input  logic [NUM_WR*XLEN-1:0] regdata,
    output logic                   hit,
    output logic [XLEN-1:0]        data,
    output logic                   clear
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan so the last (highest-index) match overrides earlier ones.
        for (int j = 0; j < int'(NUM_WR); j++) begin
            if (wer[j] && (rd[j*AW +: AW] == addr)) begin
                hit  = 1'b1;
                data = regdata[j*XLEN +: XLEN];
            end
        end
        if (ZERO_R0 && (addr == '0)) begin
            hit  = 1'b0;
            data = '0;
        end
        clear = hit;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with per-register busy scoreboard and optional write bypass.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int unsigned XLEN    = DEF_XLEN,
    parameter int unsigned NREGS   = DEF_NREGS,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_WR  = 1,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*$clog2(NREGS)-1:0] rs,
    output logic [NUM_RD*XLEN-1:0]   rv,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic [NUM_WR-1:0]        wer,
    input  logic [NUM_WR*$clog2(NREGS)-1:0] rd,
    input  logic [NUM_WR*XLEN-1:0]   regdata,
    input  logic                     iss_valid,
    input  logic [$clog2(NREGS)-1:0] iss_rd,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [XLEN-1:0]          dbg_data
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0] r_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    logic [NREGS-1:0] upd_hit, upd_clear;
    logic [XLEN-1:0]  upd_data [NREGS];

    logic [NUM_RD-1:0] byp_hit;
    logic [XLEN-1:0]   byp_data [NUM_RD];

    for (genvar i = 0; i < int'(NREGS); i++) begin : g_upd
        localparam logic [AW-1:0] IDX = AW'(i);
        regfile_wr_arb #(
            .XLEN    (XLEN),
            .AW      (AW),
            .NUM_WR  (NUM_WR),
            .ZERO_R0 (ZERO_R0)
        ) u_arb (
            .addr    (IDX),
            .wer     (wer),
            .rd      (rd),
            .regdata (regdata),
            .hit     (upd_hit[i]),
            .data    (upd_data[i]),
            .clear   (upd_clear[i])
        );
    end

    if (BYPASS) begin : g_byp
        for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_port
            logic unused_clear;
            regfile_wr_arb #(
                .XLEN    (XLEN),
                .AW      (AW),
                .NUM_WR  (NUM_WR),
                .ZERO_R0 (ZERO_R0)
            ) u_arb (
                .addr    (rs[k*AW +: AW]),
                .wer     (wer),
                .rd      (rd),
                .regdata (regdata),
                .hit     (byp_hit[k]),
                .data    (byp_data[k]),
                .clear   (unused_clear)
            );
        end
    end else begin : g_no_byp
        always_comb begin
            byp_hit = '0;
            for (int k = 0; k < int'(NUM_RD); k++) begin
                byp_data[k] = '0;
            end
        end
    end

    // Issue set is applied after write clear so a same-cycle producer stays outstanding.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (upd_clear[i]) begin
                busy_d[i] = 1'b0;
            end
            if (iss_valid && (iss_rd == AW'(i)) && !(ZERO_R0 && (i == 0))) begin
                busy_d[i] = 1'b1;
            end
        end
        if (rst) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (upd_hit[i]) begin
                    r_q[i] <= upd_data[i];
                end
            end
        end
        busy_q <= busy_d;
    end

    always_comb begin
        logic [AW-1:0] idx;
        rv    = '0;
        rbusy = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            idx = rs[k*AW +: AW];
            if (BYPASS && byp_hit[k]) begin
                rv[k*XLEN +: XLEN] = byp_data[k];
                rbusy[k]           = busy_d[idx];
            end else begin
                rv[k*XLEN +: XLEN] = r_q[idx];
                rbusy[k]           = busy_q[idx];
            end
        end
    end

    assign dbg_data = r_q[dbg_addr];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: expectations queued at drive time, popped at observation.
module tb_regfile_mp_sb;
    import regfile_mp_sb_pkg::*;

    localparam int unsigned AW = DEF_AW;
    localparam int unsigned XL = DEF_XLEN;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*AW-1:0] rs;
    logic [2*XL-1:0] rv;
    logic [1:0]      rbusy;
    logic [1:0]      wer;
    logic [2*AW-1:0] rd;
    logic [2*XL-1:0] regdata;
    logic            iss_valid;
    regidx_t         iss_rd;
    regidx_t         dbg_addr;
    xword_t          dbg_data;

    int vectors = 0;
    int miscompares = 0;

    xword_t exp_q[$];
    string  tag_q[$];

    always #5 clk = ~clk;

    regfile_mp_sb #(
        .XLEN    (XL),
        .NREGS   (DEF_NREGS),
        .NUM_RD  (2),
        .NUM_WR  (2),
        .BYPASS  (1'b1),
        .ZERO_R0 (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs        (rs),
        .rv        (rv),
        .rbusy     (rbusy),
        .wer       (wer),
        .rd        (rd),
        .regdata   (regdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    task automatic expect_val(input string tag, input xword_t exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic compare(input xword_t obs);
        xword_t exp;
        string  tag;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h required=%h", tag, obs, exp);
            end
        end
    endtask

    // Advance past the next rising edge, leaving inputs stable away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic xword_t b2w(input logic b);
        return {{(XL-1){1'b0}}, b};
    endfunction

    initial begin
        rst = 1'b1; rs = '0; wer = '0; rd = '0; regdata = '0;
        iss_valid = 1'b0; iss_rd = '0; dbg_addr = '0;

        // 1: reset
        tick();
        rst = 1'b0;
        rs = {5'd31, 5'd5};
        dbg_addr = 5'd31;
        settle();
        expect_val("rst_rv0", 32'h0);      compare(rv[0 +: XL]);
        expect_val("rst_rv1", 32'h0);      compare(rv[XL +: XL]);
        expect_val("rst_rbusy0", 32'h0);   compare(b2w(rbusy[0]));
        expect_val("rst_rbusy1", 32'h0);   compare(b2w(rbusy[1]));
        expect_val("rst_dbg31", 32'h0);    compare(dbg_data);

        // 2: write r7, bypass then registered
        wer = 2'b01; rd = {5'd0, 5'd7}; regdata = {32'h0, 32'hDEADBEEF};
        rs = {5'd31, 5'd7};
        settle();
        expect_val("byp_r7", 32'hDEADBEEF);  compare(rv[0 +: XL]);
        tick();
        wer = 2'b00;
        dbg_addr = 5'd7;
        settle();
        expect_val("rd_r7", 32'hDEADBEEF);   compare(rv[0 +: XL]);
        expect_val("dbg_r7", 32'hDEADBEEF);  compare(dbg_data);
        expect_val("busy_r7", 32'h0);        compare(b2w(rbusy[0]));

        // 3: r0 ignores writes
        wer = 2'b01; rd = {5'd0, 5'd0}; regdata = {32'h0, 32'h1234};
        rs = {5'd31, 5'd0};
        settle();
        expect_val("byp_r0", 32'h0);  compare(rv[0 +: XL]);
        tick();
        wer = 2'b00;
        dbg_addr = 5'd0;
        settle();
        expect_val("rd_r0", 32'h0);   compare(rv[0 +: XL]);
        expect_val("dbg_r0", 32'h0);  compare(dbg_data);

        // 4: two ports to r3, higher index wins
        wer = 2'b11; rd = {5'd3, 5'd3}; regdata = {32'hB, 32'hA};
        rs = {5'd3, 5'd0};
        settle();
        expect_val("byp_conflict_r3", 32'hB);  compare(rv[XL +: XL]);
        tick();
        wer = 2'b00;
        dbg_addr = 5'd3;
        settle();
        expect_val("rd_conflict_r3", 32'hB);   compare(rv[XL +: XL]);
        expect_val("dbg_conflict_r3", 32'hB);  compare(dbg_data);

        // 5: scoreboard on r9
        iss_valid = 1'b1; iss_rd = 5'd9;
        rs = {5'd0, 5'd9};
        settle();
        expect_val("busy9_pre", 32'h0);  compare(b2w(rbusy[0]));
        tick();
        iss_valid = 1'b0;
        settle();
        expect_val("busy9_set", 32'h1);  compare(b2w(rbusy[0]));
        wer = 2'b01; rd = {5'd0, 5'd9}; regdata = {32'h0, 32'h99};
        iss_valid = 1'b1; iss_rd = 5'd9;
        settle();
        expect_val("busy9_byp_setwins", 32'h1);  compare(b2w(rbusy[0]));
        expect_val("byp_r9", 32'h99);            compare(rv[0 +: XL]);
        tick();
        wer = 2'b00; iss_valid = 1'b0;
        settle();
        expect_val("busy9_setwins", 32'h1);  compare(b2w(rbusy[0]));
        expect_val("rd_r9", 32'h99);         compare(rv[0 +: XL]);
        wer = 2'b10; rd = {5'd9, 5'd0}; regdata = {32'h100, 32'h0};
        settle();
        expect_val("busy9_byp_clear", 32'h0);  compare(b2w(rbusy[0]));
        tick();
        wer = 2'b00;
        settle();
        expect_val("busy9_clear", 32'h0);  compare(b2w(rbusy[0]));
        expect_val("rd_r9_new", 32'h100);  compare(rv[0 +: XL]);

        // Issue to r0 is ignored
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        iss_valid = 1'b0;
        settle();
        expect_val("busy_r0", 32'h0);  compare(b2w(rbusy[1]));

        // 6: reset drops same-cycle write and issue
        wer = 2'b01; rd = {5'd0, 5'd4}; regdata = {32'h0, 32'h77};
        iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        wer = 2'b00; iss_valid = 1'b0;
        rs = {5'd7, 5'd4};
        settle();
        expect_val("rd_r4_pre", 32'h77);   compare(rv[0 +: XL]);
        expect_val("busy4_pre", 32'h1);    compare(b2w(rbusy[0]));
        rst = 1'b1;
        wer = 2'b01; rd = {5'd0, 5'd4}; regdata = {32'h0, 32'h55};
        iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        rst = 1'b0; wer = 2'b00; iss_valid = 1'b0;
        dbg_addr = 5'd4;
        settle();
        expect_val("rst_r4", 32'h0);     compare(rv[0 +: XL]);
        expect_val("rst_busy4", 32'h0);  compare(b2w(rbusy[0]));
        expect_val("rst_dbg4", 32'h0);   compare(dbg_data);
        expect_val("rst_r7", 32'h0);     compare(rv[XL +: XL]);

        if (exp_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
